aes_core_feeder: RTL and testbench

- Upstream sequencer for the pipelined AES_enc / AES_dec cores. Converts a valid/ready block stream plus a key-load request into the core's control protocol:
  - one-cycle fsm_en pulse to start key expansion;
  - a key-setup wait;
  - one-cycle enable pulses with IN.
- Tracks in-flight blocks and emits a valid flag aligned with the core's OUT.
- Drains the pipeline before any key change.

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_core_feeder_if.sv | 34 +++
 rtl/aes_valid_delay.sv | 27 ++
 rtl/aes_core_feeder.sv | 115 +++++++++++
 tb/tb_aes_core_feeder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES core feeder.
// Holds the feeder state encoding and default core timing.
package aes_pkg;

    localparam int AES_BLK_W        = 128;
    localparam int AES_CORE_LATENCY = 11;
    localparam int AES_KEY_SETUP    = 3;

    typedef enum logic [2:0] {
        IDLE,
        KEY_PULSE,
        KEY_WAIT,
        RUN,
        DRAIN
    } feeder_state_t;

endpackage

// File: rtl/aes_core_feeder_if.sv
// Stream, key and core-side signal bundle for the AES core feeder.
// slave is the feeder's view, master is the surrounding system's view.
interface aes_core_feeder_if #(
    parameter int DATA_W = 128
);

    logic              k_valid;
    logic [DATA_W-1:0] k_data;
    logic              k_ready;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              core_fsm_en;
    logic              core_en;
    logic [DATA_W-1:0] core_in;
    logic [DATA_W-1:0] core_key;
    logic [DATA_W-1:0] core_out;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              busy;

    modport slave (
        input  k_valid, k_data, s_valid, s_data, core_out,
        output k_ready, s_ready, core_fsm_en, core_en,
        output core_in, core_key, m_valid, m_data, busy
    );

    modport master (
        output k_valid, k_data, s_valid, s_data, core_out,
        input  k_ready, s_ready, core_fsm_en, core_en,
        input  core_in, core_key, m_valid, m_data, busy
    );

endinterface

// File: rtl/aes_valid_delay.sv
// Fixed-depth 1-bit delay line that re-times core_en into m_valid.
// Reset empties the line so results already in the core are dropped.
module aes_valid_delay #(
    parameter int DEPTH = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/aes_core_feeder.sv
// Sequencer feeding a pipelined AES core: key pulse, setup wait, block issue.
// Define AES_FEEDER_STATS_EN to add the blk_cnt / key_cnt counters.
module aes_core_feeder
    import aes_pkg::*;
#(
    parameter int CORE_LATENCY = AES_CORE_LATENCY,
    parameter int KEY_SETUP    = AES_KEY_SETUP,
    parameter int DATA_W       = AES_BLK_W
) (
    input  logic                clk,
    input  logic                rst,
    aes_core_feeder_if.slave    bus
`ifdef AES_FEEDER_STATS_EN
    ,
    output logic [31:0]         blk_cnt,
    output logic [15:0]         key_cnt
`endif
);

    localparam int IW = $clog2(CORE_LATENCY + 2);
    localparam int CW = (KEY_SETUP > 1) ? $clog2(KEY_SETUP) : 1;

    feeder_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] inflight;
    logic          k_fire;
    logic          s_fire;

    // Keys are only taken with an empty pipeline, so no result mixes keys.
    assign bus.k_ready = (state == IDLE) ||
                         ((state == RUN || state == DRAIN) && inflight == '0);
    assign bus.s_ready = (state == RUN) && !bus.k_valid;
    assign bus.busy    = (state != IDLE);
    assign bus.m_data  = bus.core_out;

    assign k_fire = bus.k_valid && bus.k_ready;
    assign s_fire = bus.s_valid && bus.s_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (k_fire) state_nxt = KEY_PULSE;
            end
            KEY_PULSE: begin
                if (KEY_SETUP <= 1) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = KEY_WAIT;
                    cnt_nxt   = CW'(KEY_SETUP - 1);
                end
            end
            KEY_WAIT: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt <= CW'(1)) state_nxt = RUN;
            end
            RUN: begin
                if (k_fire) state_nxt = KEY_PULSE;
                else if (bus.k_valid) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (k_fire) state_nxt = KEY_PULSE;
                else if (inflight == '0 && !bus.k_valid) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            inflight        <= '0;
            bus.core_fsm_en <= 1'b0;
            bus.core_en     <= 1'b0;
            bus.core_in     <= '0;
            bus.core_key    <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            bus.core_fsm_en <= (state == KEY_PULSE);
            bus.core_en     <= s_fire;
            if (s_fire) bus.core_in <= bus.s_data[DATA_W-1:0];
            if (k_fire) bus.core_key <= bus.k_data[DATA_W-1:0];
            unique case ({s_fire, bus.m_valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    aes_valid_delay #(
        .DEPTH (CORE_LATENCY)
    ) u_valid_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.core_en),
        .dout (bus.m_valid)
    );

`ifdef AES_FEEDER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt <= '0;
            key_cnt <= '0;
        end else begin
            if (bus.m_valid) blk_cnt <= blk_cnt + 1'b1;
            if (k_fire) key_cnt <= key_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_core_feeder.sv
// Directed bench for aes_core_feeder with a known-answer AES core stand-in.
// Honours AES_FEEDER_STATS_EN for the optional counters.
module tb_aes_core_feeder;

    localparam int LAT = 11;
    localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K3 = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dec_mode = 1'b0;

    aes_core_feeder_if #(.DATA_W(128)) bus ();

`ifdef AES_FEEDER_STATS_EN
    logic [31:0] blk_cnt;
    logic [15:0] key_cnt;
`endif

    aes_core_feeder #(
        .CORE_LATENCY (LAT),
        .KEY_SETUP    (3),
        .DATA_W       (128)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef AES_FEEDER_STATS_EN
        ,
        .blk_cnt (blk_cnt),
        .key_cnt (key_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Known-answer stand-in: FIPS-197 C.1 vector, otherwise in ^ key.
    function automatic logic [127:0] core_f(logic [127:0] din, logic [127:0] key, logic dec);
        if (!dec && din == PT && key == K) return CT;
        if (dec && din == CT && key == K) return PT;
        return din ^ key;
    endfunction

    logic [127:0] pipe [LAT];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= core_f(bus.core_in, bus.core_key, dec_mode);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bus.core_out = pipe[LAT-1];

    int checks = 0;
    int failures = 0;
    int mv_cnt = 0;
    int fe_cnt = 0;
    int mv_at_fe = 0;
    int peak = 0;
    int cyc = 0;
    int mv_cyc [$];
    logic [127:0] mq [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.m_valid) begin
            mq.push_back(bus.m_data);
            mv_cyc.push_back(cyc);
            mv_cnt++;
        end
        if (bus.core_fsm_en) begin
            fe_cnt++;
            mv_at_fe = mv_cnt;
        end
        if (int'(dut.inflight) > peak) peak = int'(dut.inflight);
    end

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int bad;
        int base;
        int fe0;
        logic [127:0] v;

        bus.k_valid = 1'b0;
        bus.k_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_fsm_en", 128'(bus.core_fsm_en), 128'(0));
        chk("rst_core_en", 128'(bus.core_en), 128'(0));
        chk("rst_m_valid", 128'(bus.m_valid), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_core_in", bus.core_in, 128'(0));
        chk("rst_core_key", bus.core_key, 128'(0));
        chk("rst_k_ready", 128'(bus.k_ready), 128'(1));
        chk("rst_s_ready", 128'(bus.s_ready), 128'(0));
        rst = 1'b1;
        tick();

        // Key load and setup wait
        bus.k_valid = 1'b1;
        bus.k_data  = K;
        #1;
        chk("idle_k_ready", 128'(bus.k_ready), 128'(1));
        tick();
        bus.k_valid = 1'b0;
        chk("kp_busy", 128'(bus.busy), 128'(1));
        chk("kp_core_key", bus.core_key, K);
        chk("kp_fsm_en", 128'(bus.core_fsm_en), 128'(0));
        tick();
        chk("kw_fsm_en_hi", 128'(bus.core_fsm_en), 128'(1));
        chk("kw0_s_ready", 128'(bus.s_ready), 128'(0));
        tick();
        chk("kw1_fsm_en_lo", 128'(bus.core_fsm_en), 128'(0));
        chk("kw1_s_ready", 128'(bus.s_ready), 128'(0));
        tick();
        chk("run_s_ready", 128'(bus.s_ready), 128'(1));
        bus.s_valid = 1'b1;
        bus.s_data  = PT;
        tick();
        bus.s_valid = 1'b0;
        chk("first_core_en", 128'(bus.core_en), 128'(1));
        chk("first_core_in", bus.core_in, PT);
        chk("fsm_en_pulses", 128'(fe_cnt), 128'(1));

        // Single encrypt block
        n = 0;
        while (!bus.m_valid && n < 30) begin
            tick();
            n++;
            if (n == 1) chk("core_en_one_cycle", 128'(bus.core_en), 128'(0));
        end
        chk("enc_latency", 128'(n), 128'(11));
        chk("enc_m_data", bus.m_data, CT);
        tick();
        chk("enc_m_valid_one", 128'(bus.m_valid), 128'(0));

        // Decrypt path
        dec_mode = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = CT;
        #1;
        chk("dec_s_ready", 128'(bus.s_ready), 128'(1));
        tick();
        bus.s_valid = 1'b0;
        n = 0;
        while (!bus.m_valid && n < 30) begin
            tick();
            n++;
        end
        chk("dec_latency", 128'(n), 128'(11));
        chk("dec_m_data", bus.m_data, PT);
        tick();
        dec_mode = 1'b0;

        // Stream of 12 back-to-back blocks
        mq.delete();
        mv_cyc.delete();
        peak = 0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = {4{32'(i + 'h100)}};
            #1;
            if (!bus.s_ready) bad++;
            tick();
        end
        bus.s_valid = 1'b0;
        chk("stream_s_ready", 128'(bad), 128'(0));
        n = 0;
        while (mq.size() < 12 && n < 40) begin
            tick();
            n++;
        end
        tick();
        chk("stream_count", 128'(mq.size()), 128'(12));
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            v = {4{32'(i + 'h100)}} ^ K;
            if (i >= mq.size() || mq[i] !== v) bad++;
        end
        chk("stream_order", 128'(bad), 128'(0));
        if (mv_cyc.size() == 12)
            chk("stream_back2back", 128'(mv_cyc[11] - mv_cyc[0]), 128'(11));
        chk("stream_peak", 128'(peak), 128'(12));
        chk("stream_drained", 128'(dut.inflight), 128'(0));

        // Key change with 5 blocks in flight
        mq.delete();
        base = mv_cnt;
        fe0 = fe_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = {4{32'(i + 'h200)}};
            tick();
        end
        bus.s_data  = 128'hbad0;
        bus.k_valid = 1'b1;
        bus.k_data  = K3;
        #1;
        chk("drain_s_ready", 128'(bus.s_ready), 128'(0));
        chk("drain_k_ready", 128'(bus.k_ready), 128'(0));
        tick();
        tick();
        bus.k_data = K2;
        n = 0;
        while (fe_cnt == fe0 && n < 40) begin
            tick();
            n++;
        end
        bus.k_valid = 1'b0;
        bus.s_valid = 1'b0;
        chk("drain_fsm_en_seen", 128'(fe_cnt), 128'(fe0 + 1));
        chk("drain_mv_before_fe", 128'(mv_at_fe - base), 128'(5));
        chk("drain_new_key", bus.core_key, K2);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            v = {4{32'(i + 'h200)}} ^ K;
            if (i >= mq.size() || mq[i] !== v) bad++;
        end
        chk("drain_old_key_data", 128'(bad), 128'(0));
        n = 0;
        while (!bus.s_ready && n < 20) begin
            tick();
            n++;
        end
        chk("drain_back_to_run", 128'(bus.s_ready), 128'(1));
        repeat (15) tick();
        chk("drain_no_extra", 128'(mv_cnt - base), 128'(5));
`ifdef AES_FEEDER_STATS_EN
        chk("stats_blk_cnt", 128'(blk_cnt), 128'(19));
        chk("stats_key_cnt", 128'(key_cnt), 128'(2));
`endif

        // Reset with 4 blocks in flight
        base = mv_cnt;
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = {4{32'(i + 'h300)}};
            tick();
        end
        bus.s_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_core_en", 128'(bus.core_en), 128'(0));
        chk("mid_rst_fsm_en", 128'(bus.core_fsm_en), 128'(0));
        chk("mid_rst_m_valid", 128'(bus.m_valid), 128'(0));
        chk("mid_rst_busy", 128'(bus.busy), 128'(0));
        chk("mid_rst_core_in", bus.core_in, 128'(0));
        chk("mid_rst_core_key", bus.core_key, 128'(0));
`ifdef AES_FEEDER_STATS_EN
        chk("mid_rst_blk_cnt", 128'(blk_cnt), 128'(0));
        chk("mid_rst_key_cnt", 128'(key_cnt), 128'(0));
`endif
        tick();
        rst = 1'b1;
        repeat (20) tick();
        chk("post_rst_no_mv", 128'(mv_cnt - base), 128'(0));
        chk("post_rst_idle", 128'(bus.busy), 128'(0));
        chk("post_rst_k_ready", 128'(bus.k_ready), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
